piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter that pairs with the team's 8-bit serial-in shift register receiver. It accepts a parallel word through a valid/ready handshake and drives a serial data line plus a one-cycle shift strobe, paced by an internal divider. The outputs connect directly to the receiver's `data` and `shift_enable` inputs, so that a receiver shifting left with its LSB input reconstructs the original word.

## Interface
- `WIDTH`, default 8: word width in bits, ≥ 2.
- `DIV`, default 1: clocks per serial bit, ≥ 1. A value of 1 strobes every cycle.
- `MSB_FIRST`, default 1: 1 transmits bit WIDTH-1 first (the receiver-compatible order); 0 transmits bit 0 first.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset values listed below.
- `load_data` in WIDTH: word to transmit.
- `load_valid` in 1: `load_data` is valid this cycle.
- `load_ready` out 1: block can accept a word. The transfer occurs on any edge where `load_valid` and `load_ready` are both high.
- `clear` in 1: synchronous abort; returns the block to IDLE.
- `serial_data` out 1: current serial bit.
- `serial_shift` out 1: one-cycle strobe; the receiver samples `serial_data` at the edge ending this cycle.
- `busy` out 1: high in SHIFT and DONE.
- `done` out 1: one-cycle pulse after the last bit has been shifted.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **Internal registers:**
  - `shreg` (WIDTH bits)
  - `bit_cnt` (`$clog2(WIDTH+1)` bits)
  - `div_cnt` (`max(1,$clog2(DIV))` bits)
- **IDLE:**
  - `load_ready`=1.
  - On accept: `shreg`←`load_data`, `bit_cnt`←0, `div_cnt`←0, go to SHIFT.
  - `load_valid` without accept is ignored.
- **SHIFT:**
  - `load_ready`=0.
  - `div_cnt` increments each cycle, wrapping from DIV-1 to 0.
  - `serial_shift` = (state==SHIFT && `div_cnt`==DIV-1). It is decoded from registers only and never from inputs.
  - On a strobe edge:
    - MSB_FIRST=1: `shreg` shifts left with 0 filling the LSB.
    - MSB_FIRST=0: `shreg` shifts right with 0 filling the MSB.
    - `bit_cnt` increments.
  - On the strobe edge where `bit_cnt`==WIDTH-1, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **`serial_data`:**
  - MSB_FIRST=1: `shreg[WIDTH-1]`.
  - MSB_FIRST=0: `shreg[0]`.
  - `shreg` is zero-filled in IDLE, so `serial_data` is 0 outside a frame after reset, abort or a completed frame.
- **`clear`:**
  - In any state, `clear` forces the next state to IDLE and clears `shreg`, `bit_cnt` and `div_cnt`.
  - `done` is not pulsed.
  - `clear` has priority over an accept in the same cycle, so the word is dropped and not accepted.
- **Reset values:**
  - state=IDLE, `shreg`=0, counters=0.
  - `load_ready`=1, `serial_data`=0, `serial_shift`=0, `busy`=0, `done`=0.
- **Reset mid-frame:** the frame is abandoned immediately (asynchronously). There is no partial strobe and no `done`.

## Timing
- Edge E0 is the accept edge. Cycle n is the cycle following edge E0+n-1; cycle 1 is the cycle right after E0.
- In cycle 1, `serial_data` already shows the first bit.
- Strobe k (k = 0..WIDTH-1) is high during cycle (k+1)·DIV.
- `serial_data` is stable for the whole DIV-cycle bit period that ends in each strobe.
- `done` is high in cycle WIDTH·DIV+1.
- `load_ready` returns high in cycle WIDTH·DIV+2. The earliest next accept is at the edge ending that cycle.
- Frame occupancy is WIDTH·DIV+1 cycles busy. There is no back-to-back overlap.
- With DIV=1, `serial_shift` is high in every SHIFT cycle.

## Test plan
- **Basic frame, MSB first:** WIDTH=8, DIV=1; accept 8'hA5. Required response:
  - strobes in cycles 1..8 carry 1,0,1,0,0,1,0,1;
  - `done` in cycle 9;
  - `load_ready` high in cycle 10.
- **Divider and loopback:** DIV=4, with the serial-in shift register receiver connected (reset first). Sending 8'b00000101 leaves the receiver output at 8'b00000101. Strobes occur in cycles 4,8,…,32 and `done` in cycle 33.
- **Reset mid-frame:** assert `reset` after 3 strobes of 8'hFF. Required response:
  - all outputs go to their reset values at once;
  - no `done` pulse;
  - a following 8'h3C frame transmits 0,0,1,1,1,1,0,0.
- **Abort and handshake:**
  - `clear` after 5 strobes gives IDLE next cycle and no `done`.
  - `load_valid` held high with 8'h77 during the preceding SHIFT is not accepted.
  - `clear` and accept in the same cycle leaves the block in IDLE.
- **LSB first:** MSB_FIRST=0, DIV=1, 8'h01. The first strobe carries 1 and the next 7 carry 0; `serial_data` reads 0 after `done`.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Parallel load handshake plus serial line toward the shift-register receiver.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             clear;
    logic             serial_data;
    logic             serial_shift;
    logic             busy;
    logic             done;

    modport master (
        output load_data, load_valid, clear,
        input  load_ready, serial_data, serial_shift, busy, done
    );

    modport slave (
        input  load_data, load_valid, clear,
        output load_ready, serial_data, serial_shift, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// PISO transmitter: first bit on serial_data the cycle after accept, one strobe every DIV cycles, done at WIDTH*DIV+1.
// load_ready only in IDLE; a word offered while busy is simply left waiting, and clear beats a same-cycle accept.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   tx
);
    localparam int             BW       = $clog2(WIDTH + 1);
    localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic             ready_c;
    logic             busy_c;
    logic             done_c;
    logic             strobe;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode state and counters only, so the strobe never depends on inputs.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        strobe    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (tx.load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                strobe = (div_cnt == DIV_LAST);
                if (strobe && (bit_cnt == BIT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (tx.clear) begin
            state_nxt = IDLE;
        end
    end

    assign accept = (state == IDLE) && tx.load_valid && !tx.clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (tx.clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (accept) begin
            shreg   <= tx.load_data;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else if (state == SHIFT) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            if (strobe) begin
                bit_cnt <= bit_cnt + BW'(1);
                // Zero fill leaves shreg empty by DONE, so serial_data idles low.
                if (MSB_FIRST) begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                end
            end
        end
    end

    assign tx.load_ready   = ready_c;
    assign tx.busy         = busy_c;
    assign tx.done         = done_c;
    assign tx.serial_shift = strobe;
    assign tx.serial_data  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: tb/tb_piso_serializer.sv
// Three serializer instances (MSB/DIV1, MSB/DIV4, LSB/DIV1) checked cycle by cycle against a frame-timing model.
module tb_piso_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [2:0][7:0] ld;
    logic [2:0]      lv;
    logic [2:0]      clr;
    logic [2:0][7:0] rx;

    int n_cmp = 0;
    int n_bad = 0;

    piso_serializer_if #(.WIDTH(8)) if_a ();
    piso_serializer_if #(.WIDTH(8)) if_b ();
    piso_serializer_if #(.WIDTH(8)) if_c ();

    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_dut_a (.clk(clk), .reset(reset), .tx(if_a));
    piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_dut_b (.clk(clk), .reset(reset), .tx(if_b));
    piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_dut_c (.clk(clk), .reset(reset), .tx(if_c));

    assign if_a.load_data = ld[0];  assign if_a.load_valid = lv[0];  assign if_a.clear = clr[0];
    assign if_b.load_data = ld[1];  assign if_b.load_valid = lv[1];  assign if_b.clear = clr[1];
    assign if_c.load_data = ld[2];  assign if_c.load_valid = lv[2];  assign if_c.clear = clr[2];

    // Receivers: MSB-first ones shift left taking the LSB, the LSB-first one shifts right.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx <= '0;
        end else begin
            if (if_a.serial_shift) rx[0] <= {rx[0][6:0], if_a.serial_data};
            if (if_b.serial_shift) rx[1] <= {rx[1][6:0], if_b.serial_data};
            if (if_c.serial_shift) rx[2] <= {if_c.serial_data, rx[2][7:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] obs(input int id);
        case (id)
            0:       return {if_a.load_ready, if_a.busy, if_a.done, if_a.serial_shift, if_a.serial_data};
            1:       return {if_b.load_ready, if_b.busy, if_b.done, if_b.serial_shift, if_b.serial_data};
            default: return {if_c.load_ready, if_c.busy, if_c.done, if_c.serial_shift, if_c.serial_data};
        endcase
    endfunction

    function automatic int div_of(input int id);
        return (id == 1) ? 4 : 1;
    endfunction

    function automatic bit msb_of(input int id);
        return (id != 2);
    endfunction

    // Expected {load_ready, busy, done, serial_shift, serial_data} in cycle n after the accept (n=0: idle).
    function automatic logic [4:0] model(input int n, input logic [7:0] w, input int div, input bit msb);
        int total;
        int k;
        logic b;
        total = 8 * div;
        if (n >= 1 && n <= total) begin
            k = (n - 1) / div;
            b = msb ? w[7 - k] : w[k];
            return {1'b0, 1'b1, 1'b0, (n % div) == 0, b};
        end else if (n == total + 1) begin
            return 5'b01100;
        end
        return 5'b10000;
    endfunction

    task automatic idle_cycles(input int id, input int cnt, input string what);
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("d%0d_%s_idle%0d", id, what, i), obs(id), model(0, 8'h00, 1, 1'b1));
            @(negedge clk);
        end
    endtask

    // Entered and left at a negedge with the target idle.
    task automatic run_frame(input int id, input logic [7:0] w, input bit hold,
                             input int abort_strobes, input bit by_reset);
        int  div;
        bit  msb;
        int  total;
        int  stop_n;
        div    = div_of(id);
        msb    = msb_of(id);
        total  = 8 * div;
        stop_n = (abort_strobes > 0) ? abort_strobes * div : total + 2;
        chk($sformatf("d%0d_pre_ready", id), obs(id), model(0, w, div, msb));
        ld[id] = w;
        lv[id] = 1'b1;
        @(negedge clk);
        if (hold) ld[id] = 8'h77;
        else      lv[id] = 1'b0;
        for (int n = 1; n <= stop_n; n++) begin
            if (n == total + 1) lv[id] = 1'b0;
            chk($sformatf("d%0d_w%02h_c%0d", id, w, n), obs(id), model(n, w, div, msb));
            if (n < stop_n) @(negedge clk);
        end
        if (abort_strobes == 0) begin
            chk($sformatf("d%0d_rx_%02h", id, w), rx[id], w);
        end else if (by_reset) begin
            lv[id] = 1'b0;
            #2 reset = 1'b1;
            #1;
            chk("rst_mid_a", obs(0), 5'b10000);
            chk("rst_mid_b", obs(1), 5'b10000);
            chk("rst_mid_c", obs(2), 5'b10000);
            @(negedge clk);
            reset = 1'b0;
            idle_cycles(id, 3, "postrst");
        end else begin
            lv[id]  = 1'b0;
            clr[id] = 1'b1;
            @(negedge clk);
            clr[id] = 1'b0;
            idle_cycles(id, 3, "postclr");
        end
    endtask

    task automatic clear_and_accept(input int id);
        ld[id]  = 8'hC3;
        lv[id]  = 1'b1;
        clr[id] = 1'b1;
        @(negedge clk);
        lv[id]  = 1'b0;
        clr[id] = 1'b0;
        idle_cycles(id, 2, "clracc");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        int         id;
        int         ab;
        bit         hold;
        ld    = '0;
        lv    = '0;
        clr   = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_a", obs(0), 5'b10000);
        chk("reset_b", obs(1), 5'b10000);
        chk("reset_c", obs(2), 5'b10000);
        reset = 1'b0;
        @(negedge clk);

        run_frame(0, 8'hA5, 1'b0, 0, 1'b0);
        run_frame(0, 8'h5A, 1'b0, 0, 1'b0);
        run_frame(1, 8'h05, 1'b0, 0, 1'b0);
        run_frame(0, 8'hFF, 1'b0, 3, 1'b1);
        run_frame(0, 8'h3C, 1'b0, 0, 1'b0);
        run_frame(1, 8'hFF, 1'b0, 3, 1'b1);
        run_frame(1, 8'h3C, 1'b0, 0, 1'b0);
        run_frame(0, 8'hE7, 1'b1, 5, 1'b0);
        run_frame(1, 8'h96, 1'b1, 5, 1'b0);
        clear_and_accept(0);
        clear_and_accept(1);
        clear_and_accept(2);
        run_frame(2, 8'h01, 1'b0, 0, 1'b0);
        run_frame(2, 8'hB2, 1'b1, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            id   = $urandom_range(0, 2);
            w    = 8'($urandom);
            hold = 1'($urandom_range(0, 1));
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame(id, w, hold, ab, 1'b0);
            idle_cycles(id, $urandom_range(0, 2), "gap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
